keypad_scan_controller: RTL and testbench

- Sequences the 4x4 keypad matrix. Drives one row at a time, waits a settle time, then samples the synchronized column lines.
- Reports a single pressed key (row index, column index, key_detected) to the key decoder and debouncer.
- Freezes on the active row while a key is held or while the debouncer asserts scan_stop.
- Rejects multi-key (ghosting) samples.

---
 rtl/keypad_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad row scanner: drives one row, settles, samples synchronized columns, locks on a single key.
// Optional idle wake mode (all rows driven, no counting) is enabled by defining KEYPAD_WAKE_EN.
module keypad_scan_controller #(
  parameter int SETTLE_CYCLES   = 3000,
  parameter int SYNC_STAGES     = 2,
  parameter int WAKE_IDLE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic       scan_stop,
  output logic [3:0] row,
  output logic [1:0] row_idx,
  output logic [1:0] col_idx,
  output logic       key_detected,
  output logic       multi_key
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < SYNC_STAGES + 1 || SYNC_STAGES < 1 || WAKE_IDLE_SCANS < 1) begin : g_bad_params
    $error("keypad_scan_controller: invalid parameter combination");
  end

  typedef enum logic [1:0] {SETTLE, SAMPLE, LOCK, WAKE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       col_sync [SYNC_STAGES];
  logic [3:0]       col_s;
  logic [3:0]       lock_col;
  logic             released;
  logic             rel_hit;
  logic             col_one_hot;

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] col_encode(input logic [3:0] c);
    case (c)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) col_sync[i] <= '0;
    end else begin
      col_sync[0] <= col;
      for (int i = 1; i < SYNC_STAGES; i++) col_sync[i] <= col_sync[i-1];
    end
  end

  assign col_s       = col_sync[SYNC_STAGES-1];
  assign col_one_hot = (col_s != 4'b0) && ((col_s & (col_s - 4'd1)) == 4'b0);
  // A lone column outside the locked one means the original key let go; never relock in place.
  assign rel_hit     = !scan_stop && (col_s != 4'b0) && ((col_s & lock_col) == 4'b0);

`ifdef KEYPAD_WAKE_EN
  localparam int IDLE_W = $clog2(WAKE_IDLE_SCANS + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              scan_hit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= SETTLE;
      cnt          <= '0;
      row          <= 4'b0001;
      row_idx      <= 2'd0;
      col_idx      <= 2'd0;
      lock_col     <= 4'b0;
      released     <= 1'b0;
      key_detected <= 1'b0;
      multi_key    <= 1'b0;
`ifdef KEYPAD_WAKE_EN
      idle_cnt     <= '0;
      scan_hit     <= 1'b0;
`endif
    end else begin
      key_detected <= 1'b0;
      multi_key    <= 1'b0;
      case (state)
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (col_one_hot) begin
            col_idx      <= col_encode(col_s);
            lock_col     <= col_s;
            released     <= 1'b0;
            key_detected <= 1'b1;
            state        <= LOCK;
          end else begin
            multi_key <= (col_s != 4'b0);
            row_idx   <= row_idx + 2'd1;
            row       <= row_onehot(row_idx + 2'd1);
            state     <= SETTLE;
          end
`ifdef KEYPAD_WAKE_EN
          if (col_s != 4'b0) idle_cnt <= '0;
          if (row_idx == 2'd3) begin
            scan_hit <= 1'b0;
            if (!scan_hit && col_s == 4'b0) begin
              if (idle_cnt == IDLE_W'(WAKE_IDLE_SCANS - 1)) begin
                row     <= 4'b1111;
                row_idx <= row_idx;
                state   <= WAKE;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          end else begin
            scan_hit <= scan_hit | (col_s != 4'b0);
          end
`endif
        end
        LOCK: begin
          if (col_s == 4'b0 && !scan_stop) begin
            row_idx  <= row_idx + 2'd1;
            row      <= row_onehot(row_idx + 2'd1);
            released <= 1'b0;
            cnt      <= '0;
            state    <= SETTLE;
          end else begin
            released     <= released | rel_hit;
            key_detected <= !(released | rel_hit) && (col_s == lock_col);
            multi_key    <= ((col_s & lock_col) != 4'b0) && ((col_s & ~lock_col) != 4'b0);
          end
        end
`ifdef KEYPAD_WAKE_EN
        WAKE: begin
          if (col_s != 4'b0) begin
            row_idx  <= 2'd0;
            row      <= 4'b0001;
            cnt      <= '0;
            idle_cnt <= '0;
            scan_hit <= 1'b0;
            state    <= SETTLE;
          end
        end
`endif
        default: begin
          cnt   <= '0;
          state <= SETTLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller with SETTLE_CYCLES=4, SYNC_STAGES=2, WAKE_IDLE_SCANS=2.
module tb_keypad_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic        scan_stop = 1'b0;
  logic [3:0]  row;
  logic [1:0]  row_idx;
  logic [1:0]  col_idx;
  logic        key_detected;
  logic        multi_key;
  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c held down

  int checks = 0;
  int failures = 0;

  keypad_scan_controller #(
    .SETTLE_CYCLES(4),
    .SYNC_STAGES(2),
    .WAKE_IDLE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col(col),
    .scan_stop(scan_stop),
    .row(row),
    .row_idx(row_idx),
    .col_idx(col_idx),
    .key_detected(key_detected),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Key matrix: a column reads 1 when a pressed key sits on a driven row.
  always_comb begin
    col = 4'b0;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | keys[r*4 +: 4];
  end

  typedef struct {
    logic        rst_n;
    logic [15:0] keys;
    logic        stop;
    int          n;
    logic [3:0]  row;
    logic [1:0]  ridx;
    logic [1:0]  cidx;
    logic        kd;
    logic        mk;
  } vec_t;

  vec_t       vecs[35];
  logic [9:0] exp_q[$];

  function automatic vec_t make_vec(logic r, logic [15:0] k, logic s, int n,
                                    logic [3:0] ro, logic [1:0] ri, logic [1:0] ci,
                                    logic kd, logic mk);
    vec_t v;
    v.rst_n = r; v.keys = k; v.stop = s; v.n = n;
    v.row = ro; v.ridx = ri; v.cidx = ci; v.kd = kd; v.mk = mk;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] exp_v;
    int         ones;

    // Vector list: inputs applied, then n clock edges, then outputs compared.
    vecs[0]  = make_vec(0, 16'h0000, 0, 2, 4'b0001, 0, 0, 0, 0);
    vecs[1]  = make_vec(1, 16'h0040, 0, 9, 4'b0010, 1, 0, 0, 0);
    vecs[2]  = make_vec(1, 16'h0040, 0, 1, 4'b0010, 1, 2, 1, 0);
    vecs[3]  = make_vec(1, 16'h0000, 0, 1, 4'b0010, 1, 2, 1, 0);
    vecs[4]  = make_vec(1, 16'h0000, 0, 1, 4'b0010, 1, 2, 1, 0);
    vecs[5]  = make_vec(1, 16'h0000, 0, 1, 4'b0100, 2, 2, 0, 0);
    vecs[6]  = make_vec(1, 16'h0200, 0, 4, 4'b0100, 2, 2, 0, 0);
    vecs[7]  = make_vec(1, 16'h0200, 0, 1, 4'b0100, 2, 1, 1, 0);
    vecs[8]  = make_vec(1, 16'h0000, 1, 2, 4'b0100, 2, 1, 1, 0);
    vecs[9]  = make_vec(1, 16'h0000, 1, 1, 4'b0100, 2, 1, 0, 0);
    vecs[10] = make_vec(1, 16'h0000, 1, 3, 4'b0100, 2, 1, 0, 0);
    vecs[11] = make_vec(1, 16'h0000, 0, 1, 4'b1000, 3, 1, 0, 0);
    vecs[12] = make_vec(1, 16'h0003, 0, 9, 4'b0001, 0, 1, 0, 0);
    vecs[13] = make_vec(1, 16'h0003, 0, 1, 4'b0010, 1, 1, 0, 1);
    vecs[14] = make_vec(1, 16'h0100, 0, 1, 4'b0010, 1, 1, 0, 0);
    vecs[15] = make_vec(1, 16'h0100, 0, 4, 4'b0100, 2, 1, 0, 0);
    vecs[16] = make_vec(1, 16'h0100, 0, 4, 4'b0100, 2, 1, 0, 0);
    vecs[17] = make_vec(1, 16'h0100, 0, 1, 4'b0100, 2, 0, 1, 0);
    vecs[18] = make_vec(1, 16'h0900, 0, 2, 4'b0100, 2, 0, 1, 0);
    vecs[19] = make_vec(1, 16'h0900, 0, 1, 4'b0100, 2, 0, 0, 1);
    vecs[20] = make_vec(1, 16'h0900, 0, 1, 4'b0100, 2, 0, 0, 1);
    vecs[21] = make_vec(1, 16'h0000, 0, 2, 4'b0100, 2, 0, 0, 1);
    vecs[22] = make_vec(1, 16'h0000, 0, 1, 4'b1000, 3, 0, 0, 0);
    vecs[23] = make_vec(1, 16'h4000, 0, 4, 4'b1000, 3, 0, 0, 0);
    vecs[24] = make_vec(1, 16'h4000, 0, 1, 4'b1000, 3, 2, 1, 0);
    vecs[25] = make_vec(0, 16'h4000, 0, 1, 4'b0001, 0, 0, 0, 0);
    vecs[26] = make_vec(1, 16'h4000, 0, 4, 4'b0001, 0, 0, 0, 0);
    vecs[27] = make_vec(1, 16'h4000, 0, 1, 4'b0010, 1, 0, 0, 0);
    vecs[28] = make_vec(1, 16'h4000, 0, 14, 4'b1000, 3, 0, 0, 0);
    vecs[29] = make_vec(1, 16'h4000, 0, 1, 4'b1000, 3, 2, 1, 0);
    vecs[30] = make_vec(1, 16'h2000, 0, 2, 4'b1000, 3, 2, 1, 0);
    vecs[31] = make_vec(1, 16'h2000, 0, 1, 4'b1000, 3, 2, 0, 0);
    vecs[32] = make_vec(1, 16'h4000, 0, 3, 4'b1000, 3, 2, 0, 0);
    vecs[33] = make_vec(1, 16'h0000, 0, 2, 4'b1000, 3, 2, 0, 0);
    vecs[34] = make_vec(1, 16'h0000, 0, 1, 4'b0001, 0, 2, 0, 0);

    // Idle scan: reset values, then each row held 5 cycles in order.
    do_reset();
    check("reset_outputs", {row, row_idx, col_idx, key_detected, multi_key},
          {4'b0001, 2'd0, 2'd0, 1'b0, 1'b0});
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      check($sformatf("idle_row[%0d]", k), row, 4'b0001 << ((k / 5) % 4));
      check($sformatf("idle_kd[%0d]", k), {key_detected, multi_key}, 2'b00);
    end

    // Lock, release, scan_stop hold, multi-key, reset in LOCK, release-and-repress.
    for (int i = 0; i < 35; i++) begin
      rst_n     = vecs[i].rst_n;
      keys      = vecs[i].keys;
      scan_stop = vecs[i].stop;
      exp_q.push_back({vecs[i].row, vecs[i].ridx, vecs[i].cidx, vecs[i].kd, vecs[i].mk});
      for (int c = 0; c < vecs[i].n; c++) tick();
      exp_v = exp_q.pop_front();
      check($sformatf("vec[%0d]", i), {row, row_idx, col_idx, key_detected, multi_key}, exp_v);
    end

`ifdef KEYPAD_WAKE_EN
    keys = 16'h0;
    do_reset();
    for (int c = 0; c < 45; c++) tick();
    check("wake_row", row, 4'b1111);
    check("wake_kd", key_detected, 1'b0);
    keys = 16'h0080;
    tick();
    tick();
    tick();
    check("wake_exit_row", {row, row_idx}, {4'b0001, 2'd0});
    for (int c = 0; c < 40 && !key_detected; c++) tick();
    check("wake_relock_kd", key_detected, 1'b1);
    check("wake_relock_pos", {row, row_idx, col_idx}, {4'b0010, 2'd1, 2'd3});
`else
    keys = 16'h0;
    do_reset();
    ones = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (row == 4'b1111) ones++;
    end
    check("no_wake_rows", ones, 0);
    check("no_wake_final_row", row, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
